// File: rtl/axis_bram_reader_if.sv
// axis_bram_reader_if: AXI-stream handshake bundle between the reader and its sink.
interface axis_bram_reader_if #(
    parameter int WORD_WIDTH = 32
);
    logic [WORD_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_bram_reader.sv
// axis_bram_reader: streams BRAM rows start..bound (inclusive, wrapping) as AXI-stream words,
// double-buffering rows so consecutive rows flow without a valid bubble.
module axis_bram_reader #(
    parameter int BRAM_ADDR_LENGTH   = 12,
    parameter int BRAM_WIDTH_IN_WORD = 36,
    parameter int WORD_WIDTH         = 32
) (
    input  logic                                       clk,
    input  logic                                       rstn,
    input  logic                                       start,
    input  logic [BRAM_ADDR_LENGTH-1:0]                bram_start_index,
    input  logic [BRAM_ADDR_LENGTH-1:0]                bram_bound_index,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       bram_en,
    output logic [BRAM_ADDR_LENGTH-1:0]                bram_index,
    input  logic [WORD_WIDTH*BRAM_WIDTH_IN_WORD-1:0]   bram_rdata,
    axis_bram_reader_if.master                         m_axis
);
    localparam int CW = $clog2(BRAM_WIDTH_IN_WORD);
    localparam logic [CW-1:0] LAST = CW'(BRAM_WIDTH_IN_WORD - 1);
    typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_t;
    state_t state;
    logic [BRAM_WIDTH_IN_WORD-1:0][WORD_WIDTH-1:0] act, pre;
    logic pre_full, pend;
    logic [BRAM_ADDR_LENGTH-1:0] cur_row, bound, nxt_row;
    logic [CW-1:0] cnt;
    logic hs;
    assign hs = m_axis.tvalid && m_axis.tready;
    assign nxt_row = cur_row + 1'b1;
    assign m_axis.tdata = act[cnt];
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            bram_en       <= 1'b0;
            bram_index    <= '0;
            m_axis.tvalid <= 1'b0;
            m_axis.tlast  <= 1'b0;
            act           <= '0;
            pre           <= '0;
            pre_full      <= 1'b0;
            pend          <= 1'b0;
            cur_row       <= '0;
            bound         <= '0;
            cnt           <= '0;
        end else begin
            // a prefetch read issued last cycle has its row on bram_rdata now
            pend <= (state == STREAM) && bram_en;
            if (pend) begin
                pre      <= bram_rdata;
                pre_full <= 1'b1;
            end
            case (state)
                IDLE: if (start) begin
                    state      <= FETCH;
                    busy       <= 1'b1;
                    bram_en    <= 1'b1;
                    bram_index <= bram_start_index;
                    cur_row    <= bram_start_index;
                    bound      <= bram_bound_index;
                end
                FETCH: if (bram_en) bram_en <= 1'b0;
                else begin
                    act           <= bram_rdata;
                    cnt           <= '0;
                    m_axis.tvalid <= 1'b1;
                    m_axis.tlast  <= 1'b0;
                    state         <= STREAM;
                    if (cur_row != bound) begin
                        bram_en    <= 1'b1;
                        bram_index <= nxt_row;
                    end
                end
                STREAM: begin
                    bram_en <= 1'b0;
                    if (hs) begin
                        if (cnt == LAST) begin
                            cnt          <= '0;
                            m_axis.tlast <= 1'b0;
                            if (cur_row == bound) begin
                                state         <= DONE;
                                m_axis.tvalid <= 1'b0;
                                busy          <= 1'b0;
                                done          <= 1'b1;
                            end else begin
                                // width >= 3 guarantees the prefetch landed before this swap
                                act      <= pre;
                                pre_full <= 1'b0;
                                cur_row  <= nxt_row;
                                if (nxt_row != bound) begin
                                    bram_en    <= 1'b1;
                                    bram_index <= nxt_row + 1'b1;
                                end
                            end
                        end else begin
                            cnt          <= cnt + 1'b1;
                            m_axis.tlast <= (cnt + 1'b1 == LAST) && (cur_row == bound);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_bram_reader.sv
// tb_axis_bram_reader: directed transfers against a BRAM model with hand-derived word patterns.
module tb_axis_bram_reader;
    localparam int AL = 12;
    localparam int W  = 36;
    localparam int WW = 32;
    logic clk = 1'b0;
    logic rstn, start, busy, done, bram_en;
    logic [AL-1:0] bram_start_index, bram_bound_index, bram_index;
    logic [WW*W-1:0] bram_rdata = '0;
    int n_cmp = 0, n_bad = 0;
    axis_bram_reader_if #(.WORD_WIDTH(WW)) axis ();
    axis_bram_reader dut (
        .clk(clk), .rstn(rstn), .start(start),
        .bram_start_index(bram_start_index), .bram_bound_index(bram_bound_index),
        .busy(busy), .done(done), .bram_en(bram_en), .bram_index(bram_index),
        .bram_rdata(bram_rdata), .m_axis(axis)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] wd(input logic [AL-1:0] r, input int k);
        logic [11:0] kk;
        kk = 12'(k);
        return {8'h5A, r, kk};
    endfunction
    always @(posedge clk) if (bram_en) for (int k = 0; k < W; k++) bram_rdata[k*WW +: WW] <= wd(bram_index, k);
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic xfer(input logic [AL-1:0] s, input logic [AL-1:0] b, input int nrows,
                        input bit stall, input int pulse_at, input int rst_at);
        int cyc, beats, first, last_hs, gaps;
        logic [AL-1:0] reads[$];
        logic [31:0] hold_d;
        logic hold_l, holding, fin;
        logic [AL-1:0] row;
        cyc = 0; beats = 0; first = -1; last_hs = -1; gaps = 0; holding = 0; fin = 0;
        @(negedge clk);
        start = 1'b1; bram_start_index = s; bram_bound_index = b;
        while (!fin && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = (beats == pulse_at);
            if (start) begin bram_start_index = s + 12'd100; bram_bound_index = s + 12'd200; end
            if (rst_at >= 0 && beats == rst_at) begin
                rstn = 1'b0; axis.tready = 1'b1;
                @(negedge clk);
                chk("abort_tvalid", axis.tvalid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_bram_en", bram_en, 0);
                rstn = 1'b1;
                return;
            end
            axis.tready = stall ? logic'(cyc % 2) : 1'b1;
            if (bram_en) reads.push_back(bram_index);
            if (holding) begin
                chk("stall_tdata", axis.tdata, hold_d);
                chk("stall_tlast", axis.tlast, hold_l);
            end
            if (axis.tvalid && first < 0) begin
                first = cyc;
                chk("first_latency", cyc, 3);
                chk("busy_active", busy, 1);
            end
            if (axis.tvalid && axis.tready) begin
                row = s + AL'(beats / W);
                chk("tdata", axis.tdata, wd(row, beats % W));
                chk("tlast", axis.tlast, beats == nrows*W - 1);
                if (last_hs >= 0 && cyc != last_hs + 1) gaps++;
                last_hs = cyc;
                beats++;
            end
            holding = axis.tvalid && !axis.tready;
            hold_d = axis.tdata;
            hold_l = axis.tlast;
            if (done) begin
                chk("done_lat", cyc, last_hs + 1);
                chk("done_busy", busy, 0);
                chk("done_tvalid", axis.tvalid, 0);
                fin = 1;
            end
        end
        chk("finished", fin, 1);
        chk("beats", beats, nrows*W);
        if (!stall) chk("gaps", gaps, 0);
        chk("reads", reads.size(), nrows);
        for (int i = 0; i < reads.size() && i < nrows; i++) chk("read_index", reads[i], AL'(s + AL'(i)));
        @(negedge clk);
        chk("idle_done", done, 0);
    endtask
    initial begin
        rstn = 1'b0; start = 1'b0; axis.tready = 1'b0;
        bram_start_index = '0; bram_bound_index = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bram_en", bram_en, 0);
        chk("rst_tvalid", axis.tvalid, 0);
        chk("rst_tlast", axis.tlast, 0);
        chk("rst_index", bram_index, 0);
        rstn = 1'b1;
        @(negedge clk);
        xfer(12'd5, 12'd5, 1, 0, -1, -1);
        xfer(12'd0, 12'd2, 3, 0, -1, -1);
        xfer(12'd7, 12'd7, 1, 1, -1, -1);
        xfer(12'd4095, 12'd0, 2, 0, -1, -1);
        xfer(12'd3, 12'd4, 2, 0, 10, 20);
        xfer(12'd9, 12'd9, 1, 0, -1, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axis_bram_reader.md
AXIS_BRAM_READER -- requirements
Module: axis_bram_reader

Interface
REQ-001 Parameter BRAM_ADDR_LENGTH, default 12: BRAM row address width.
REQ-002 Parameter BRAM_WIDTH_IN_WORD, default 36: stream words per BRAM row; legal range 3..63.
REQ-003 Parameter WORD_WIDTH, default 32: stream word width in bits.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rstn  input  1  synchronous, active-low reset.
REQ-006 start  input  1  request to begin a transfer; sampled in IDLE only.
REQ-007 bram_start_index  input  BRAM_ADDR_LENGTH  first row to read; sampled on start acceptance.
REQ-008 bram_bound_index  input  BRAM_ADDR_LENGTH  last row to read, inclusive; sampled on start acceptance.
REQ-009 busy  output  1  high from the cycle after start acceptance until the cycle of the done pulse.
REQ-010 done  output  1  one-cycle pulse after the final handshake.
REQ-011 bram_en  output  1  BRAM read enable; read-only port, no write enable.
REQ-012 bram_index  output  BRAM_ADDR_LENGTH  BRAM row address.
REQ-013 bram_rdata  input  WORD_WIDTH*BRAM_WIDTH_IN_WORD  row data, valid exactly one cycle after bram_en is sampled high.
REQ-014 m_axis_tdata  output  WORD_WIDTH  stream data.
REQ-015 m_axis_tvalid  output  1  stream valid.
REQ-016 m_axis_tready  input  1  stream ready from the sink.
REQ-017 m_axis_tlast  output  1  marks the last word of the transfer.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, STREAM and DONE; reset enters IDLE.
REQ-019 In IDLE with start=1, the block SHALL latch both indices and enter FETCH; start in any other state SHALL be ignored.
REQ-020 In FETCH, the block SHALL drive bram_en=1 and bram_index=start row for one cycle, capture bram_rdata into the active row buffer on the following cycle, then enter STREAM.
REQ-021 First-word latency SHALL be exactly 3 cycles: start at cycle T gives m_axis_tvalid=1 at T+3.
REQ-022 Word k of a row (k=0..BRAM_WIDTH_IN_WORD-1) SHALL be bram_rdata[k*WORD_WIDTH +: WORD_WIDTH], lowest word first.
REQ-023 A word counter SHALL advance only on handshake (tvalid && tready) and wrap to 0 after BRAM_WIDTH_IN_WORD-1.
REQ-024 While tvalid=1 and tready=0, tdata and tlast SHALL hold stable.
REQ-025 When the active row is not the bound row and the prefetch buffer is empty, the block SHALL issue one read of the next row (bram_en=1 for one cycle) and capture it into the prefetch buffer one cycle later.
REQ-026 On the handshake of word BRAM_WIDTH_IN_WORD-1, a full prefetch buffer SHALL move into the active buffer in the same cycle, with no tvalid bubble between rows.
REQ-027 Row addresses SHALL increment modulo 2^BRAM_ADDR_LENGTH: bound<start wraps through the top row; start==bound reads exactly one row.
REQ-028 tlast SHALL be 1 only on word BRAM_WIDTH_IN_WORD-1 of the bound row.
REQ-029 After the tlast handshake, the FSM SHALL enter DONE for one cycle (done=1, busy=0, tvalid=0), then return to IDLE.
REQ-030 bram_en SHALL be 0 except on issue cycles; each row SHALL be read exactly once per transfer.

Reset
REQ-031 rstn=0 at any clock edge SHALL set state IDLE; busy, done, bram_en, m_axis_tvalid and m_axis_tlast to 0; bram_index, counters and row buffers to 0; both buffers empty.
REQ-032 Reset mid-transfer SHALL abandon the transfer with no further handshakes; the first start after release SHALL behave as a fresh transfer.

Verification
REQ-033 start=5, bound=5, tready=1 -> one bram_en with index 5, 36 beats on consecutive cycles starting at T+3, tlast on beat 36, done one cycle after.
REQ-034 start=0, bound=2, tready=1 -> 108 contiguous beats, bram_index reads 0,1,2 in order, tlast only on beat 108.
REQ-035 start=7, bound=7, tready alternating 1/0 -> tdata/tlast stable while stalled, 36 beats in row word order.
REQ-036 BRAM_ADDR_LENGTH=12, start=4095, bound=0 -> reads of rows 4095 then 0, 72 beats, tlast on beat 72.
REQ-037 start pulsed at beat 10 of a transfer -> ignored, transfer unchanged; rstn=0 at beat 20 -> next cycle tvalid=0, busy=0, bram_en=0; new start after release -> first word at T+3.
